// File: rtl/clock_setting_controller.sv
// Button-driven edit controller for the 24-hour clock core: time/alarm setting,
// display muxing, edit-field blink, edit timeout and alarm silencing.
module clock_setting_controller #(
   parameter int TIMEOUT_CYCLES = 1250000000,
   parameter int BLINK_HALF     = 62500000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic       btn_confirm,
   input  logic [6:0] cur_hour,
   input  logic [6:0] cur_minute,
   input  logic       alarm_ring,
   output logic [6:0] setup_hour,
   output logic [6:0] setup_minute,
   output logic       setup_ready,
   output logic [6:0] alarm_hour,
   output logic [6:0] alarm_minute,
   output logic       alarm_ready,
   output logic [2:0] state,
   output logic [6:0] disp_hour,
   output logic [6:0] disp_minute,
   output logic       blink,
   output logic       buzzer
);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HOUR = 3'd1,
      SET_MIN  = 3'd2,
      ALM_HOUR = 3'd3,
      ALM_MIN  = 3'd4
   } state_t;

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

   state_t        state_q, state_d;
   logic [6:0]    edit_hour, edit_hour_d, edit_minute, edit_minute_d;
   logic [6:0]    setup_hour_d, setup_minute_d, alarm_hour_d, alarm_minute_d;
   logic          setup_ready_d, alarm_ready_d, blink_d;
   logic          silenced, silenced_d;
   logic [TW-1:0] tmo_cnt, tmo_cnt_d;
   logic [BW-1:0] blink_cnt, blink_cnt_d;
   logic          any_btn, accept, hour_field;

   function automatic logic [6:0] wrap_step(input logic [6:0] v, input logic [6:0] top,
                                            input logic up);
      if (up) return (v >= top) ? 7'd0 : v + 7'd1;
      else    return (v == 7'd0) ? top : v - 7'd1;
   endfunction

   // A press while the alarm is sounding unsilenced only silences it.
   assign any_btn    = btn_mode | btn_inc | btn_dec | btn_confirm;
   assign accept     = any_btn & ~(alarm_ring & ~silenced);
   assign hour_field = (state_q == SET_HOUR) || (state_q == ALM_HOUR);

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      state_d        = state_q;
      edit_hour_d    = edit_hour;
      edit_minute_d  = edit_minute;
      setup_hour_d   = setup_hour;
      setup_minute_d = setup_minute;
      setup_ready_d  = 1'b0;
      alarm_hour_d   = alarm_hour;
      alarm_minute_d = alarm_minute;
      alarm_ready_d  = alarm_ready;
      silenced_d     = alarm_ring ? (silenced | any_btn) : 1'b0;

      if (accept) begin
         if (btn_mode) begin
            case (state_q)
               RUN: begin
                  state_d       = SET_HOUR;
                  edit_hour_d   = cur_hour;
                  edit_minute_d = cur_minute;
               end
               SET_HOUR, SET_MIN: begin
                  state_d       = ALM_HOUR;
                  edit_hour_d   = alarm_hour;
                  edit_minute_d = alarm_minute;
               end
               default: state_d = RUN;
            endcase
         end else if (btn_confirm) begin
            case (state_q)
               RUN:      alarm_ready_d = ~alarm_ready;
               SET_HOUR: state_d = SET_MIN;
               SET_MIN: begin
                  state_d        = RUN;
                  setup_hour_d   = edit_hour;
                  setup_minute_d = edit_minute;
                  setup_ready_d  = 1'b1;
               end
               ALM_HOUR: state_d = ALM_MIN;
               ALM_MIN: begin
                  state_d        = RUN;
                  alarm_hour_d   = edit_hour;
                  alarm_minute_d = edit_minute;
                  alarm_ready_d  = 1'b1;
               end
               default: state_d = RUN;
            endcase
         end else if ((btn_inc ^ btn_dec) && state_q != RUN) begin
            if (hour_field) edit_hour_d   = wrap_step(edit_hour, 7'd23, btn_inc);
            else            edit_minute_d = wrap_step(edit_minute, 7'd59, btn_inc);
         end
      end else if (state_q != RUN && tmo_cnt == TMO_LAST) begin
         state_d = RUN;
      end

      // Both counters restart on any state change and idle at zero in RUN.
      if (state_q == RUN || state_d != state_q) begin
         tmo_cnt_d   = '0;
         blink_cnt_d = '0;
         blink_d     = 1'b0;
      end else begin
         tmo_cnt_d = accept ? '0 : tmo_cnt + TW'(1);
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink;
         end else begin
            blink_cnt_d = blink_cnt + BW'(1);
            blink_d     = blink;
         end
      end
   end

   // NOTE: registers are updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RUN;
         edit_hour    <= '0;
         edit_minute  <= '0;
         setup_hour   <= '0;
         setup_minute <= '0;
         setup_ready  <= 1'b0;
         alarm_hour   <= '0;
         alarm_minute <= '0;
         alarm_ready  <= 1'b0;
         silenced     <= 1'b0;
         tmo_cnt      <= '0;
         blink_cnt    <= '0;
         blink        <= 1'b0;
      end else begin
         state_q      <= state_d;
         edit_hour    <= edit_hour_d;
         edit_minute  <= edit_minute_d;
         setup_hour   <= setup_hour_d;
         setup_minute <= setup_minute_d;
         setup_ready  <= setup_ready_d;
         alarm_hour   <= alarm_hour_d;
         alarm_minute <= alarm_minute_d;
         alarm_ready  <= alarm_ready_d;
         silenced     <= silenced_d;
         tmo_cnt      <= tmo_cnt_d;
         blink_cnt    <= blink_cnt_d;
         blink        <= blink_d;
      end
   end

   assign state       = state_q;
   assign disp_hour   = (state_q == RUN) ? cur_hour : edit_hour;
   assign disp_minute = (state_q == RUN) ? cur_minute : edit_minute;
   assign buzzer      = alarm_ring & ~silenced;

endmodule

// File: tb/tb_clock_setting_controller.sv
// Scoreboarded bench for clock_setting_controller: a cycle-level reference model
// predicts every output; a monitor checks outputs and each setup_ready commit.
module tb_clock_setting_controller;

   localparam int TMO = 100;
   localparam int BH  = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_confirm = 1'b0;
   logic [6:0] cur_hour = '0, cur_minute = '0;
   logic       alarm_ring = 1'b0;
   logic [6:0] setup_hour, setup_minute, alarm_hour, alarm_minute, disp_hour, disp_minute;
   logic       setup_ready, alarm_ready, blink, buzzer;
   logic [2:0] state;

   clock_setting_controller #(.TIMEOUT_CYCLES(TMO), .BLINK_HALF(BH)) dut (
      .clk(clk), .reset_n(reset_n),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_confirm(btn_confirm),
      .cur_hour(cur_hour), .cur_minute(cur_minute), .alarm_ring(alarm_ring),
      .setup_hour(setup_hour), .setup_minute(setup_minute), .setup_ready(setup_ready),
      .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm_ready(alarm_ready),
      .state(state), .disp_hour(disp_hour), .disp_minute(disp_minute),
      .blink(blink), .buzzer(buzzer)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st, sh, sm, sr, ah, am, ar, dh, dm, bl, bz;
   } exp_t;

   exp_t exp_q[$];
   int   commit_q[$];
   int   n_vec = 0;
   int   n_fail = 0;

   // Next-cycle environment values applied by tick()
   logic       nx_rst = 1'b0, nx_ring = 1'b0;
   logic [6:0] nx_ch = '0, nx_cm = '0;

   // Reference model: plain integers, "cycles since" counters instead of hardware counters
   int m_state, m_eh, m_em, m_sh, m_sm, m_sr, m_ah, m_am, m_ar, m_sil, m_idle, m_age;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic void model_reset();
      {m_state, m_eh, m_em, m_sh, m_sm, m_sr} = '0;
      {m_ah, m_am, m_ar, m_sil, m_idle, m_age} = '0;
   endfunction

   function automatic void model_update();
      int  prev = m_state;
      bit  any = btn_mode | btn_inc | btn_dec | btn_confirm;
      bit  pressed = any && !(alarm_ring && !m_sil);
      int  delta;
      m_sr  = 0;
      m_sil = alarm_ring ? int'(m_sil != 0 || any) : 0;
      if (pressed) begin
         if (btn_mode) begin
            if (m_state == 0) begin
               m_state = 1; m_eh = int'(cur_hour); m_em = int'(cur_minute);
            end else if (m_state <= 2) begin
               m_state = 3; m_eh = m_ah; m_em = m_am;
            end else m_state = 0;
         end else if (btn_confirm) begin
            case (m_state)
               0: m_ar = 1 - m_ar;
               1: m_state = 2;
               2: begin
                  m_sh = m_eh; m_sm = m_em; m_sr = 1; m_state = 0;
                  commit_q.push_back(m_eh * 100 + m_em);
               end
               3: m_state = 4;
               default: begin m_ah = m_eh; m_am = m_em; m_ar = 1; m_state = 0; end
            endcase
         end else if (btn_inc != btn_dec && m_state != 0) begin
            delta = btn_inc ? 1 : -1;
            if (m_state == 1 || m_state == 3) m_eh = (m_eh + delta + 24) % 24;
            else                              m_em = (m_em + delta + 60) % 60;
         end
      end else if (m_state != 0 && m_idle == TMO - 1) begin
         m_state = 0;
      end
      if (m_state != prev || m_state == 0) begin
         m_idle = 0; m_age = 0;
      end else begin
         m_idle = pressed ? 0 : m_idle + 1;
         m_age  = m_age + 1;
      end
   endfunction

   // One clock: model consumes the inputs held over the last cycle, then new inputs go out
   task automatic tick(input logic m, input logic i, input logic d, input logic c);
      exp_t e;
      @(posedge clk);
      if (reset_n) model_update();
      #2;
      reset_n = nx_rst; alarm_ring = nx_ring; cur_hour = nx_ch; cur_minute = nx_cm;
      btn_mode = m; btn_inc = i; btn_dec = d; btn_confirm = c;
      if (!nx_rst) model_reset();
      e.st = m_state; e.sh = m_sh; e.sm = m_sm; e.sr = m_sr;
      e.ah = m_ah; e.am = m_am; e.ar = m_ar;
      e.dh = (m_state == 0) ? int'(cur_hour) : m_eh;
      e.dm = (m_state == 0) ? int'(cur_minute) : m_em;
      e.bl = (m_state == 0) ? 0 : (m_age / BH) % 2;
      e.bz = int'(alarm_ring) & (1 - m_sil);
      exp_q.push_back(e);
   endtask

   task automatic press(input logic m, input logic i, input logic d, input logic c);
      tick(m, i, d, c);
      tick(0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(0, 0, 0, 0);
   endtask

   exp_t mon_e;
   int   mon_c;
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check("state", 32'(state), mon_e.st);
         check("setup_hour", 32'(setup_hour), mon_e.sh);
         check("setup_minute", 32'(setup_minute), mon_e.sm);
         check("setup_ready", 32'(setup_ready), mon_e.sr);
         check("alarm_hour", 32'(alarm_hour), mon_e.ah);
         check("alarm_minute", 32'(alarm_minute), mon_e.am);
         check("alarm_ready", 32'(alarm_ready), mon_e.ar);
         check("disp_hour", 32'(disp_hour), mon_e.dh);
         check("disp_minute", 32'(disp_minute), mon_e.dm);
         check("blink", 32'(blink), mon_e.bl);
         check("buzzer", 32'(buzzer), mon_e.bz);
      end
      if (setup_ready === 1'b1) begin
         if (commit_q.size() == 0) check("unexpected_commit", 1, 0);
         else begin
            mon_c = commit_q.pop_front();
            check("commit_time", 32'(int'(setup_hour) * 100 + int'(setup_minute)), mon_c);
         end
      end
   end

   initial begin
      model_reset();
      idle(3);
      nx_rst = 1'b1;
      idle(3);
      #1 check("reset_state", 32'(state), 0);
      check("reset_setup_ready", 32'(setup_ready), 0);

      // Time set: 10:20 -> 13:55
      nx_ch = 7'd10; nx_cm = 7'd20;
      press(1, 0, 0, 0);
      repeat (3) press(0, 1, 0, 0);
      press(0, 0, 0, 1);
      repeat (25) press(0, 0, 1, 0);
      press(0, 0, 0, 1);
      #1 check("commit_pulse", 32'(setup_ready), 1);
      check("commit_hour", 32'(setup_hour), 13);
      check("commit_minute", 32'(setup_minute), 55);
      check("commit_state", 32'(state), 0);
      tick(0, 0, 0, 0);
      #1 check("commit_pulse_end", 32'(setup_ready), 0);

      // Wrap boundaries
      nx_ch = 7'd23; nx_cm = 7'd0;
      press(1, 0, 0, 0);
      press(0, 1, 0, 0);
      #1 check("hour_wrap_up", 32'(disp_hour), 0);
      press(0, 0, 1, 0);
      #1 check("hour_wrap_down", 32'(disp_hour), 23);
      press(0, 0, 0, 1);
      press(0, 0, 1, 0);
      #1 check("minute_wrap_down", 32'(disp_minute), 59);
      press(0, 1, 1, 0);
      #1 check("inc_dec_cancel", 32'(disp_minute), 59);
      press(1, 0, 0, 0);
      press(1, 0, 0, 0);

      // Alarm set 06:30, then toggle off from RUN
      press(1, 0, 0, 0);
      press(1, 0, 0, 0);
      #1 check("alm_hour_state", 32'(state), 3);
      repeat (6) press(0, 1, 0, 0);
      press(0, 0, 0, 1);
      repeat (30) press(0, 1, 0, 0);
      press(0, 0, 0, 1);
      #1 check("alarm_hour_set", 32'(alarm_hour), 6);
      check("alarm_minute_set", 32'(alarm_minute), 30);
      check("alarm_enabled", 32'(alarm_ready), 1);
      press(0, 0, 0, 1);
      #1 check("alarm_toggled_off", 32'(alarm_ready), 0);

      // Timeout: exactly TMO edges after entry, and extended by a press
      tick(1, 0, 0, 0);
      idle(100);
      #1 check("tmo_not_yet", 32'(state), 1);
      tick(0, 0, 0, 0);
      #1 check("tmo_expired", 32'(state), 0);
      tick(1, 0, 0, 0);
      idle(50);
      tick(0, 1, 0, 0);
      idle(70);
      #1 check("tmo_extended", 32'(state), 1);
      idle(45);
      #1 check("tmo_extended_expired", 32'(state), 0);

      // Alarm silencing
      nx_ring = 1'b1;
      tick(0, 0, 0, 0);
      #1 check("buzzer_on", 32'(buzzer), 1);
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      #1 check("buzzer_silenced", 32'(buzzer), 0);
      check("silence_consumed", 32'(state), 0);
      nx_ring = 1'b0;
      idle(2);
      nx_ring = 1'b1;
      tick(0, 0, 0, 0);
      #1 check("buzzer_rearmed", 32'(buzzer), 1);
      nx_ring = 1'b0;
      idle(2);

      // Reset in the middle of a minute edit at 05:05
      nx_ch = 7'd5; nx_cm = 7'd5;
      press(1, 0, 0, 0);
      press(0, 0, 0, 1);
      #1 check("pre_reset_state", 32'(state), 2);
      nx_ch = 7'd0; nx_cm = 7'd0; nx_rst = 1'b0;
      tick(0, 0, 0, 0);
      #1 check("reset_mid_state", 32'(state), 0);
      check("reset_mid_setup_hour", 32'(setup_hour), 0);
      nx_rst = 1'b1;
      idle(5);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 39) == 0) nx_ring = ~nx_ring;
         if ($urandom_range(0, 7) == 0) begin
            nx_ch = 7'($urandom_range(0, 23));
            nx_cm = 7'($urandom_range(0, 59));
         end
         if ($urandom_range(0, 199) == 0) idle(105);
         tick($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      end
      idle(3);
      @(negedge clk);
      @(negedge clk);
      check("commits_drained", 32'(commit_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
